// File: rtl/maj_net_pkg.sv
// Shared types for the majority-gate network evaluator.
//   state_e : controller states
//   gate_t  : one gate-program entry (three operand selects plus complement bits)
//   node_w  : width of a node select for a given input/gate count
package maj_net_pkg;

    // Select fields are stored at a fixed width so the entry type stays parameter-free.
    // node_w(NUM_IN, MAX_GATES) must not exceed this.
    localparam int unsigned SelW = 8;

    typedef enum logic [1:0] {
        StIdle,
        StEval,
        StDone
    } state_e;

    typedef struct packed {
        logic [SelW-1:0] sel_a;
        logic [SelW-1:0] sel_b;
        logic [SelW-1:0] sel_c;
        logic [2:0]      inv;   // {c, b, a}
    } gate_t;

    function automatic int unsigned node_w(input int unsigned num_in,
                                           input int unsigned max_gates);
        return $clog2(1 + num_in + max_gates);
    endfunction

endpackage

// File: rtl/maj3_cell.sv
// Three-input majority with optional per-operand complement.
//   a_i, b_i, c_i : operand values
//   inv_i         : complement bits {c, b, a}
//   y_o           : maj(a^inv[0], b^inv[1], c^inv[2])
module maj3_cell (
    input  logic       a_i,
    input  logic       b_i,
    input  logic       c_i,
    input  logic [2:0] inv_i,
    output logic       y_o
);

    logic a, b, c;

    always_comb begin
        a   = a_i ^ inv_i[0];
        b   = b_i ^ inv_i[1];
        c   = c_i ^ inv_i[2];
        y_o = (a & b) | (a & c) | (b & c);
    end

endmodule

// File: rtl/maj_net_eval.sv
// Programmable majority-gate network evaluator. A small program memory describes up to
// MAX_GATES majority gates; one shared maj3_cell evaluates one gate per cycle. Single mode
// evaluates the network for in_vec, sweep mode builds the full truth table.
//   clk, rst                     : clock, synchronous active-high reset
//   cfg_we/cfg_addr/cfg_sel_*/cfg_inv : program write port (ignored while busy)
//   cfg_num_gates                : active gate count, sampled at accept
//   in_valid/in_ready/in_vec/mode: request handshake
//   out_valid/out_ready          : result handshake
//   out_bit, tt_out              : single-mode result, sweep truth table
//   busy                         : controller not idle
module maj_net_eval
    import maj_net_pkg::*;
#(
    parameter int unsigned NUM_IN    = 7,
    parameter int unsigned MAX_GATES = 16,
    localparam int unsigned NODE_W   = node_w(NUM_IN, MAX_GATES),
    localparam int unsigned AW       = $clog2(MAX_GATES),
    localparam int unsigned GW       = $clog2(MAX_GATES + 1),
    localparam int unsigned NVEC     = 2 ** NUM_IN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [AW-1:0]     cfg_addr,
    input  logic [NODE_W-1:0] cfg_sel_a,
    input  logic [NODE_W-1:0] cfg_sel_b,
    input  logic [NODE_W-1:0] cfg_sel_c,
    input  logic [2:0]        cfg_inv,
    input  logic [GW-1:0]     cfg_num_gates,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [NUM_IN-1:0] in_vec,
    input  logic              mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_bit,
    output logic [NVEC-1:0]   tt_out,
    output logic              busy
);

    localparam int unsigned NumNodes = 1 + NUM_IN + MAX_GATES;

    state_e               state_q, state_d;
    logic [NUM_IN-1:0]    in_vec_q, in_vec_d;
    logic [NUM_IN-1:0]    vec_cnt_q, vec_cnt_d;
    logic                 mode_q, mode_d;
    logic [GW-1:0]        g_q, g_d;
    logic [AW-1:0]        gate_idx_q, gate_idx_d;
    logic [MAX_GATES-1:0] gate_val_q, gate_val_d;
    logic [NVEC-1:0]      tt_acc_q, tt_acc_d;
    logic [NVEC-1:0]      tt_out_q, tt_out_d;
    logic                 out_bit_q, out_bit_d;
    logic                 out_valid_q, out_valid_d;

    gate_t prog_q [MAX_GATES];

    logic [NUM_IN-1:0] cur_vec;
    gate_t             cur_gate;
    logic              op_a, op_b, op_c, cell_y;
    logic              last_gate, fn_val;

    // Node 0 is constant 0, then the inputs, then the gate values. Out-of-range selects
    // read 0; gates not yet evaluated for this vector are still cleared and read 0 too.
    function automatic logic node_val(input logic [SelW-1:0]      sel,
                                      input logic [NUM_IN-1:0]    x,
                                      input logic [MAX_GATES-1:0] gv);
        logic [NumNodes-1:0] nodes;
        nodes = {gv, x, 1'b0};
        if (32'(sel) < NumNodes) begin
            return nodes[sel[NODE_W-1:0]];
        end
        return 1'b0;
    endfunction

    // Program memory: deliberately not reset so the program survives rst.
    always_ff @(posedge clk) begin
        if (cfg_we && (state_q == StIdle) && (32'(cfg_addr) < MAX_GATES)) begin
            prog_q[cfg_addr] <= '{sel_a: SelW'(cfg_sel_a),
                                  sel_b: SelW'(cfg_sel_b),
                                  sel_c: SelW'(cfg_sel_c),
                                  inv:   cfg_inv};
        end
    end

    always_comb begin
        cur_vec  = mode_q ? vec_cnt_q : in_vec_q;
        cur_gate = prog_q[gate_idx_q];
        op_a     = node_val(cur_gate.sel_a, cur_vec, gate_val_q);
        op_b     = node_val(cur_gate.sel_b, cur_vec, gate_val_q);
        op_c     = node_val(cur_gate.sel_c, cur_vec, gate_val_q);
    end

    maj3_cell u_cell (
        .a_i   (op_a),
        .b_i   (op_b),
        .c_i   (op_c),
        .inv_i (cur_gate.inv),
        .y_o   (cell_y)
    );

    always_comb begin
        state_d     = state_q;
        in_vec_d    = in_vec_q;
        vec_cnt_d   = vec_cnt_q;
        mode_d      = mode_q;
        g_d         = g_q;
        gate_idx_d  = gate_idx_q;
        gate_val_d  = gate_val_q;
        tt_acc_d    = tt_acc_q;
        tt_out_d    = tt_out_q;
        out_bit_d   = out_bit_q;
        out_valid_d = out_valid_q;

        // G = 0 still spends one EVAL cycle and yields 0.
        last_gate = (g_q == '0) || (GW'(gate_idx_q) + GW'(1) == g_q);
        fn_val    = (g_q == '0) ? 1'b0 : cell_y;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    state_d    = StEval;
                    in_vec_d   = in_vec;
                    mode_d     = mode;
                    g_d        = (cfg_num_gates > GW'(MAX_GATES)) ? GW'(MAX_GATES)
                                                                 : cfg_num_gates;
                    gate_idx_d = '0;
                    gate_val_d = '0;
                    vec_cnt_d  = '0;
                    tt_acc_d   = '0;
                end
            end
            StEval: begin
                gate_val_d[gate_idx_q] = cell_y;
                if (last_gate) begin
                    tt_acc_d[vec_cnt_q] = fn_val;
                    gate_idx_d          = '0;
                    gate_val_d          = '0;
                    if (!mode_q || (&vec_cnt_q)) begin
                        state_d = StDone;
                        // Results only become visible on DONE entry.
                        if (mode_q) begin
                            tt_out_d = tt_acc_d;
                        end else begin
                            out_bit_d = fn_val;
                        end
                    end else begin
                        vec_cnt_d = vec_cnt_q + NUM_IN'(1);
                    end
                end else begin
                    gate_idx_d = gate_idx_q + AW'(1);
                end
            end
            StDone: begin
                // out_valid is registered: it rises one cycle after DONE entry.
                out_valid_d = 1'b1;
                if (out_valid_q && out_ready) begin
                    state_d     = StIdle;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            in_vec_q    <= '0;
            vec_cnt_q   <= '0;
            mode_q      <= 1'b0;
            g_q         <= '0;
            gate_idx_q  <= '0;
            gate_val_q  <= '0;
            tt_acc_q    <= '0;
            tt_out_q    <= '0;
            out_bit_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_vec_q    <= in_vec_d;
            vec_cnt_q   <= vec_cnt_d;
            mode_q      <= mode_d;
            g_q         <= g_d;
            gate_idx_q  <= gate_idx_d;
            gate_val_q  <= gate_val_d;
            tt_acc_q    <= tt_acc_d;
            tt_out_q    <= tt_out_d;
            out_bit_q   <= out_bit_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign out_valid = out_valid_q;
    assign out_bit   = out_bit_q;
    assign tt_out    = tt_out_q;

endmodule

// File: tb/tb_maj_net_eval.sv
module tb_maj_net_eval;

    logic         clk = 1'b0;
    logic         rst;
    logic         cfg_we;
    logic [3:0]   cfg_addr;
    logic [4:0]   cfg_sel_a, cfg_sel_b, cfg_sel_c;
    logic [2:0]   cfg_inv;
    logic [4:0]   cfg_num_gates;
    logic         in_valid, in_ready;
    logic [6:0]   in_vec;
    logic         mode;
    logic         out_valid, out_ready;
    logic         out_bit;
    logic [127:0] tt_out;
    logic         busy;

    int errors = 0;
    int checks = 0;

    maj_net_eval #(
        .NUM_IN    (7),
        .MAX_GATES (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_we        (cfg_we),
        .cfg_addr      (cfg_addr),
        .cfg_sel_a     (cfg_sel_a),
        .cfg_sel_b     (cfg_sel_b),
        .cfg_sel_c     (cfg_sel_c),
        .cfg_inv       (cfg_inv),
        .cfg_num_gates (cfg_num_gates),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_vec        (in_vec),
        .mode          (mode),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_bit       (out_bit),
        .tt_out        (tt_out),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic prog_gate(input logic [3:0] idx, input logic [4:0] a, input logic [4:0] b,
                             input logic [4:0] c, input logic [2:0] inv);
        cfg_we    = 1'b1;
        cfg_addr  = idx;
        cfg_sel_a = a;
        cfg_sel_b = b;
        cfg_sel_c = c;
        cfg_inv   = inv;
        tick();
        cfg_we    = 1'b0;
    endtask

    task automatic load_main_prog();
        prog_gate(4'd0, 5'd1, 5'd2, 5'd6,  3'b000);
        prog_gate(4'd1, 5'd2, 5'd3, 5'd4,  3'b000);
        prog_gate(4'd2, 5'd1, 5'd2, 5'd7,  3'b000);
        prog_gate(4'd3, 5'd1, 5'd4, 5'd10, 3'b000);
        prog_gate(4'd4, 5'd5, 5'd9, 5'd11, 3'b000);
        prog_gate(4'd5, 5'd3, 5'd8, 5'd12, 3'b000);
    endtask

    // Ends right after the accept edge.
    task automatic start(input logic [6:0] v, input logic m, input logic [4:0] g);
        in_vec        = v;
        mode          = m;
        cfg_num_gates = g;
        in_valid      = 1'b1;
        tick();
        in_valid      = 1'b0;
    endtask

    // Counts edges until out_valid is seen, bounded by limit.
    task automatic wait_done(input int limit, output int cyc);
        cyc = 0;
        while (!out_valid && cyc < limit) begin
            tick();
            cyc++;
        end
    endtask

    // Single run with out_ready high; returns to IDLE before returning.
    task automatic run_single(input string tag, input logic [6:0] v, input logic [4:0] g,
                              input logic exp_bit, input int exp_lat);
        int cyc;
        start(v, 1'b0, g);
        wait_done(200, cyc);
        check_eq({tag, "_lat"}, 128'(cyc), 128'(exp_lat));
        check_eq({tag, "_bit"}, 128'(out_bit), 128'(exp_bit));
        tick();
        check_eq({tag, "_idle"}, 128'(in_ready), 128'(1'b1));
    endtask

    initial begin
        logic [127:0] tt_exp;
        logic         seen;
        int           cyc;

        tt_exp        = 128'hfeeaece0f8e8e880fee8e8e0f8c8a880;
        rst           = 1'b1;
        cfg_we        = 1'b0;
        cfg_addr      = '0;
        cfg_sel_a     = '0;
        cfg_sel_b     = '0;
        cfg_sel_c     = '0;
        cfg_inv       = '0;
        cfg_num_gates = '0;
        in_valid      = 1'b0;
        in_vec        = '0;
        mode          = 1'b0;
        out_ready     = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        check_eq("rst_in_ready", 128'(in_ready), 128'(1'b1));
        check_eq("rst_out_valid", 128'(out_valid), 128'(1'b0));
        check_eq("rst_busy", 128'(busy), 128'(1'b0));
        check_eq("rst_out_bit", 128'(out_bit), 128'(1'b0));
        check_eq("rst_tt_out", tt_out, 128'h0);

        load_main_prog();
        run_single("single_07", 7'h07, 5'd6, 1'b1, 7);
        run_single("single_06", 7'h06, 5'd6, 1'b0, 7);

        start(7'h00, 1'b1, 5'd6);
        check_eq("sweep_busy", 128'(busy), 128'(1'b1));
        check_eq("sweep_in_ready", 128'(in_ready), 128'(1'b0));
        wait_done(2000, cyc);
        check_eq("sweep_lat", 128'(cyc), 128'(769));
        check_eq("sweep_tt", tt_out, tt_exp);
        tick();

        // Abort a sweep with rst sampled on the 100th edge after accept.
        start(7'h00, 1'b1, 5'd6);
        repeat (99) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("abort_in_ready", 128'(in_ready), 128'(1'b1));
        check_eq("abort_busy", 128'(busy), 128'(1'b0));
        check_eq("abort_tt_cleared", tt_out, 128'h0);
        seen = 1'b0;
        for (int i = 0; i < 800; i++) begin
            if (out_valid) seen = 1'b1;
            tick();
        end
        check_eq("abort_no_valid", 128'(seen), 128'(1'b0));
        start(7'h00, 1'b1, 5'd6);
        wait_done(2000, cyc);
        check_eq("rerun_lat", 128'(cyc), 128'(769));
        check_eq("rerun_tt", tt_out, tt_exp);
        tick();

        // Hold in DONE with out_ready low; a program write during EVAL must be dropped.
        out_ready = 1'b0;
        start(7'h07, 1'b0, 5'd6);
        prog_gate(4'd5, 5'd0, 5'd0, 5'd0, 3'b111);
        wait_done(200, cyc);
        check_eq("hold_valid", 128'(out_valid), 128'(1'b1));
        for (int i = 0; i < 10; i++) begin
            tick();
            check_eq("hold_bit", 128'(out_bit), 128'(1'b1));
            check_eq("hold_in_ready", 128'(in_ready), 128'(1'b0));
            check_eq("hold_tt", tt_out, tt_exp);
        end
        out_ready = 1'b1;
        tick();
        check_eq("hold_release", 128'(out_valid), 128'(1'b0));
        run_single("nowrite_06", 7'h06, 5'd6, 1'b0, 7);

        // maj(x0, ~0, ~0) = 1
        prog_gate(4'd0, 5'd1, 5'd0, 5'd0, 3'b110);
        run_single("g1_inv", 7'h00, 5'd1, 1'b1, 2);
        // G = 0 yields 0 after two cycles.
        run_single("g0_zero", 7'h7f, 5'd0, 1'b0, 2);
        // A gate reading itself sees 0: maj(0, x0, 0) = 0.
        prog_gate(4'd0, 5'd8, 5'd1, 5'd0, 3'b000);
        run_single("self_read", 7'h01, 5'd1, 1'b0, 2);
        // Select 31 is beyond node 23 and reads 0: maj(0, x0, x1) with x0=1, x1=0.
        prog_gate(4'd0, 5'd31, 5'd1, 5'd2, 3'b000);
        run_single("oob_sel", 7'h01, 5'd1, 1'b0, 2);
        prog_gate(4'd0, 5'd31, 5'd1, 5'd2, 3'b001);
        run_single("oob_sel_inv", 7'h01, 5'd1, 1'b1, 2);
        // cfg_num_gates = 31 saturates to 16 gates.
        start(7'h00, 1'b0, 5'd31);
        wait_done(200, cyc);
        check_eq("sat_lat", 128'(cyc), 128'(17));
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/maj_net_eval.md
MAJ_NET_EVAL -- requirements
Module: maj_net_eval

Interface
REQ-001 Parameter NUM_IN, default 7, number of primary inputs x0..x(NUM_IN-1).
REQ-002 Parameter MAX_GATES, default 16, depth of the gate program memory.
REQ-003 Derived constant NODE_W = clog2(1+NUM_IN+MAX_GATES); node 0 = const 0, nodes 1..NUM_IN = x0..x(NUM_IN-1), node NUM_IN+1+k = gate k.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 cfg_we  in  1  gate-program write strobe.
REQ-007 cfg_addr  in  clog2(MAX_GATES)  gate index being written.
REQ-008 cfg_sel_a / cfg_sel_b / cfg_sel_c  in  NODE_W each  operand node selects.
REQ-009 cfg_inv  in  3  per-operand complement bits {c,b,a}.
REQ-010 cfg_num_gates  in  clog2(MAX_GATES+1)  active gate count G, sampled at accept.
REQ-011 in_valid / in_ready  in / out  1  request handshake.
REQ-012 in_vec  in  NUM_IN  input vector; bit i = xi.
REQ-013 mode  in  1  0 = single evaluation, 1 = full truth-table sweep; sampled at accept.
REQ-014 out_valid / out_ready  out / in  1  result handshake.
REQ-015 out_bit  out  1  single-mode result.
REQ-016 tt_out  out  2**NUM_IN  sweep result; tt_out[i] = f(vector i), x0 = LSB of i.
REQ-017 busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-018 Each gate SHALL compute maj(a^inv[0], b^inv[1], c^inv[2]) over the selected node values.
REQ-019 The FSM SHALL have states IDLE, EVAL and DONE; in_ready SHALL be 1 only in IDLE.
REQ-020 On accept (in_valid & in_ready), the block SHALL latch in_vec, mode and G, clear all gate-value registers, and enter EVAL.
REQ-021 In EVAL, the block SHALL evaluate exactly one gate per cycle in index order 0..G-1; a select naming a gate not yet evaluated for the current vector SHALL read 0.
REQ-022 The function value SHALL be the value of gate G-1; if G = 0, the value SHALL be 0 and EVAL SHALL last one cycle.
REQ-023 Single mode: out_valid SHALL rise max(G,1)+1 cycles after the accept edge, with out_bit valid.
REQ-024 Sweep mode: the block SHALL ignore in_vec and iterate vectors 0..2**NUM_IN-1 back-to-back with no idle cycles, clearing gate registers between vectors; out_valid SHALL rise 2**NUM_IN*max(G,1)+1 cycles after the accept edge, with tt_out complete.
REQ-025 In DONE, out_bit and tt_out SHALL hold stable until out_valid & out_ready; the block SHALL then return to IDLE on that same edge.
REQ-026 cfg_we SHALL write the program entry only when busy = 0; writes while busy SHALL be dropped.
REQ-027 A cfg_sel value greater than NUM_IN+MAX_GATES SHALL read as 0.
REQ-028 If cfg_num_gates > MAX_GATES at accept, G SHALL saturate to MAX_GATES.
REQ-029 The tt_out bits of the sweep currently in progress SHALL NOT be visible externally; tt_out SHALL update only on entry to DONE.

Reset
REQ-030 rst SHALL force IDLE; in_ready=1, out_valid=0, busy=0, out_bit=0, tt_out=0, and gate-value registers cleared; the vector counter SHALL be cleared.
REQ-031 rst asserted mid-EVAL or mid-DONE SHALL abort the operation with no out_valid pulse.
REQ-032 The gate program memory SHALL NOT be reset and SHALL retain its contents across rst.

Structure
REQ-033 Package maj_net_pkg SHALL hold the FSM state enum, the NODE_W function, and the gate-program entry struct {sel_a, sel_b, sel_c, inv}.
REQ-034 The 3-input majority-with-complement cell SHALL be the sub-module maj3_cell, instantiated once and time-multiplexed across gates.

Verification
REQ-035 Program NUM_IN=7, G=6: g0=(1,2,6) g1=(2,3,4) g2=(1,2,7) g3=(1,4,10) g4=(5,9,11) g5=(3,8,12), inv=0; single mode, in_vec=7'h07 -> out_bit=1; in_vec=7'h06 -> out_bit=0; each after 7 cycles.
REQ-036 Same program, sweep mode -> tt_out=128'hfeeaece0f8e8e880fee8e8e0f8c8a880, with out_valid exactly 769 cycles after accept.
REQ-037 G=1, g0=(1,0,0), inv=3'b110 -> maj(x0,1,1): out_bit=1 for in_vec=0; G=0 -> out_bit=0 after 2 cycles.
REQ-038 Hold out_ready=0 for 10 cycles in DONE -> out_bit/tt_out stable, in_ready=0; a cfg_we issued during EVAL leaves the program unchanged.
REQ-039 Assert rst on cycle 100 of a sweep -> IDLE next cycle, no out_valid; rerun without reprogramming -> identical tt_out.
